// File: rtl/nv_clk_gate_hyst_if.sv
// Control and status bundle for the multi-channel hysteresis clock gate.
// The master side (partition controller / bench) drives activity and
// configuration; the slave side (the gate) returns gated clocks and status.
interface nv_clk_gate_hyst_if #(
  parameter int NUM_CH = 4,
  parameter int HOLD_W = 4
);
  logic [HOLD_W-1:0] cfg_hold;
  logic [NUM_CH-1:0] cfg_force_on;
  logic              test_en;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] clk_gated;
  logic [NUM_CH-1:0] ch_gated;
  logic              all_gated;

  modport master (
    output cfg_hold, cfg_force_on, test_en, busy,
    input  clk_gated, ch_gated, all_gated
  );

  modport slave (
    input  cfg_hold, cfg_force_on, test_en, busy,
    output clk_gated, ch_gated, all_gated
  );
endinterface

// File: rtl/nv_clk_gate_hyst.sv
// Multi-channel clock-gate controller with idle hysteresis.
// Each channel runs an ON/HOLD/OFF FSM: after cfg_hold+1 consecutive idle
// samples the channel's enable drops, and a low-transparent latch plus AND
// produces a glitch-free gated clock. Force-on and test bypass keep clocks
// running; ch_gated/all_gated report which channels are currently stopped.
module nv_clk_gate_hyst #(
  parameter int NUM_CH = 4,
  parameter int HOLD_W = 4
) (
  input  logic                clk,
  input  logic                reset_,
  nv_clk_gate_hyst_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_ON   = 2'd0,
    ST_HOLD = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  logic [NUM_CH-1:0] clk_gated_w;
  logic [NUM_CH-1:0] ch_gated_w;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      state_t            state_reg;
      state_t            state_next;
      logic [HOLD_W-1:0] cnt_reg;
      logic [HOLD_W-1:0] cnt_next;
      logic              en_reg;
      logic              ch_gated_reg;
      logic              latch_q;
      logic              wake;

      // Either real activity or a software override keeps the channel awake.
      assign wake = bus.busy[gi] | bus.cfg_force_on[gi];

      // Idle hysteresis: countdown from cfg_hold before stopping the clock.
      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        unique case (state_reg)
          ST_ON: begin
            if (!wake) begin
              if (bus.cfg_hold == '0) begin
                state_next = ST_OFF;
              end else begin
                state_next = ST_HOLD;
                cnt_next   = bus.cfg_hold;
              end
            end
          end
          ST_HOLD: begin
            if (wake) begin
              state_next = ST_ON;
            end else if (cnt_reg == HOLD_W'(1)) begin
              state_next = ST_OFF;
            end else begin
              cnt_next = cnt_reg - HOLD_W'(1);
            end
          end
          ST_OFF: begin
            if (wake) begin
              state_next = ST_ON;
            end
          end
          default: begin
            state_next = ST_ON;
          end
        endcase
      end

      // State, counter, enable and status flops; reset lets clocks run.
      always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
          state_reg    <= ST_ON;
          cnt_reg      <= '0;
          en_reg       <= 1'b1;
          ch_gated_reg <= 1'b0;
        end else begin
          state_reg    <= state_next;
          cnt_reg      <= cnt_next;
          en_reg       <= (state_next != ST_OFF);
          ch_gated_reg <= (state_next == ST_OFF);
        end
      end

      // Enable latch is open only while clk is low, so the AND cannot glitch.
      always_latch begin
        if (!clk) begin
          latch_q <= en_reg | bus.test_en;
        end
      end

      assign clk_gated_w[gi] = clk & latch_q;
      assign ch_gated_w[gi]  = ch_gated_reg;
    end
  endgenerate

  assign bus.clk_gated = clk_gated_w;
  assign bus.ch_gated  = ch_gated_w;
  assign bus.all_gated = &ch_gated_w;

endmodule

// File: tb/tb_nv_clk_gate_hyst.sv
// Scoreboard bench for nv_clk_gate_hyst. Stimulus is applied on the falling
// edge; a reference model based on idle-run lengths predicts each following
// rising edge (gated-clock pulse and status) and queues the prediction. A
// monitor samples the DUT in every high phase, early and late, and compares.
`timescale 1ns/1ps
module tb_nv_clk_gate_hyst;
  localparam int NUM_CH = 4;
  localparam int HOLD_W = 4;

  logic clk    = 1'b0;
  logic reset_ = 1'b1;

  always #5 clk = ~clk;

  nv_clk_gate_hyst_if #(.NUM_CH(NUM_CH), .HOLD_W(HOLD_W)) bus ();

  nv_clk_gate_hyst #(.NUM_CH(NUM_CH), .HOLD_W(HOLD_W)) dut (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus)
  );

  typedef struct packed {
    logic [NUM_CH-1:0] pulse;
    logic [NUM_CH-1:0] chg;
  } exp_t;

  exp_t sb_q[$];

  int tests = 0;
  int fails = 0;

  // Reference model: length of the current idle run per channel and the
  // hold value captured on the first idle sample of that run.
  int                run_len [NUM_CH];
  int                snap    [NUM_CH];
  logic [NUM_CH-1:0] m_gated;

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      run_len[i] = 0;
      snap[i]    = 0;
    end
    m_gated = '0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus plus the prediction for the upcoming rising edge.
  task automatic drive_cycle(input logic rst_l, input logic [NUM_CH-1:0] b,
                             input logic [NUM_CH-1:0] f, input logic te,
                             input logic [HOLD_W-1:0] h);
    exp_t e;
    @(negedge clk);
    reset_           = rst_l;
    bus.busy         = b;
    bus.cfg_force_on = f;
    bus.test_en      = te;
    bus.cfg_hold     = h;
    if (!rst_l) begin
      model_reset();
      e.pulse = '1;
      e.chg   = '0;
    end else begin
      // Pulse at this edge depends on the enable left by the previous edge.
      e.pulse = ~m_gated | {NUM_CH{te}};
      for (int i = 0; i < NUM_CH; i++) begin
        if (b[i] | f[i]) begin
          run_len[i] = 0;
        end else begin
          if (run_len[i] < 1000) run_len[i]++;
          if (run_len[i] == 1) snap[i] = int'(h);
        end
        m_gated[i] = (run_len[i] >= snap[i] + 1);
      end
      e.chg = m_gated;
    end
    sb_q.push_back(e);
  endtask

  task automatic idle_cycles(input int n, input logic [NUM_CH-1:0] f,
                             input logic te, input logic [HOLD_W-1:0] h);
    for (int k = 0; k < n; k++) drive_cycle(1'b1, '0, f, te, h);
  endtask

  // Assert reset in the middle of a high phase and hold it for two cycles.
  task automatic async_reset(input logic [HOLD_W-1:0] h);
    @(posedge clk);
    #2;
    reset_ = 1'b0;
    #1;
    check("async_ch_gated", 32'(bus.ch_gated), 32'h0);
    check("async_all_gated", 32'(bus.all_gated), 32'h0);
    model_reset();
    drive_cycle(1'b0, '0, '0, 1'b0, h);
    drive_cycle(1'b0, '0, '0, 1'b0, h);
  endtask

  // Monitor: one prediction per rising edge, clk_gated sampled early and late
  // in the high phase so a runt or late pulse is caught.
  logic [NUM_CH-1:0] mon_cg_early;
  logic [NUM_CH-1:0] mon_cg_late;
  logic [NUM_CH-1:0] mon_chg;
  logic              mon_ag;
  exp_t              mon_e;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        mon_e        = sb_q.pop_front();
        mon_cg_early = bus.clk_gated;
        mon_chg      = bus.ch_gated;
        mon_ag       = bus.all_gated;
        #3;
        mon_cg_late  = bus.clk_gated;
        check("clk_gated_early", 32'(mon_cg_early), 32'(mon_e.pulse));
        check("clk_gated_late", 32'(mon_cg_late), 32'(mon_e.pulse));
        check("ch_gated", 32'(mon_chg), 32'(mon_e.chg));
        check("all_gated", 32'(mon_ag), 32'(&mon_e.chg));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NUM_CH-1:0] b;
    logic [NUM_CH-1:0] f;
    logic              te;
    logic [HOLD_W-1:0] h;
    int                pct;

    bus.busy         = '0;
    bus.cfg_force_on = '0;
    bus.test_en      = 1'b0;
    bus.cfg_hold     = 4'd3;
    model_reset();
    #1;
    reset_ = 1'b0;

    // Clocks toggle while reset is held, then gate after 4 idle samples.
    for (int k = 0; k < 3; k++) drive_cycle(1'b0, '0, '0, 1'b0, 4'd3);
    idle_cycles(8, '0, 1'b0, 4'd3);

    // Single busy pulse on channel 0 wakes it for cfg_hold+1 more samples.
    drive_cycle(1'b1, 4'b0001, '0, 1'b0, 4'd3);
    idle_cycles(7, '0, 1'b0, 4'd3);

    // cfg_hold extremes.
    drive_cycle(1'b1, 4'b1111, '0, 1'b0, 4'd0);
    idle_cycles(3, '0, 1'b0, 4'd0);
    drive_cycle(1'b1, 4'b1111, '0, 1'b0, 4'd15);
    idle_cycles(20, '0, 1'b0, 4'd15);

    // Abort mid-HOLD, then change cfg_hold mid-countdown.
    drive_cycle(1'b1, 4'b0010, '0, 1'b0, 4'd5);
    idle_cycles(3, '0, 1'b0, 4'd5);
    drive_cycle(1'b1, 4'b0010, '0, 1'b0, 4'd5);
    idle_cycles(2, '0, 1'b0, 4'd5);
    idle_cycles(6, '0, 1'b0, 4'd1);
    drive_cycle(1'b1, 4'b0010, '0, 1'b0, 4'd1);
    idle_cycles(4, '0, 1'b0, 4'd1);

    // Force-on for channels 0 and 2, then test bypass.
    idle_cycles(10, 4'b0101, 1'b0, 4'd2);
    idle_cycles(6, 4'b0101, 1'b1, 4'd2);
    idle_cycles(6, '0, 1'b0, 4'd2);

    // Randomised activity, configuration and bypass.
    b = '0; f = '0; te = 1'b0; h = 4'd2; pct = 10;
    for (int k = 0; k < 400; k++) begin
      if (k % 25 == 0) begin
        case ($urandom_range(0, 3))
          0: pct = 0;
          1: pct = 5;
          2: pct = 20;
          default: pct = 60;
        endcase
      end
      for (int i = 0; i < NUM_CH; i++) b[i] = ($urandom_range(0, 99) < pct);
      if ($urandom_range(0, 19) == 0) h = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
      if ($urandom_range(0, 29) == 0) f = ($urandom_range(0, 1) == 0) ? '0 : 4'($urandom);
      if ($urandom_range(0, 24) == 0) te = ~te;
      drive_cycle(1'b1, b, f, te, h);
    end

    // All channels off, then reset in the middle of a high phase.
    idle_cycles(8, '0, 1'b0, 4'd2);
    async_reset(4'd2);
    idle_cycles(6, '0, 1'b0, 4'd2);

    @(posedge clk);
    #6;
    check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
